noc_arbiter: RTL and testbench
==============================

NOC_ARBITER -- requirements
Module: noc_arbiter

Interface
REQ-001 The block SHALL have parameter PKT_W, default 168, giving the NoC packet width in bits (address 32 + data 128 + control 8).
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the per-input FIFO depth; legal values are powers of two, 2 to 8.
REQ-003 The block SHALL have port fclk, input, 1 bit: single fabric clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in0_pkt, input, PKT_W bits: request packet from the core port.
REQ-006 The block SHALL have port in0_valid, input, 1 bit: in0_pkt is valid.
REQ-007 The block SHALL have port in0_ready, output, 1 bit: FIFO 0 can accept a packet.
REQ-008 The block SHALL have ports in1_pkt, in1_valid and in1_ready, with widths and meanings as for input 0, serving the GPIO/second requester port.
REQ-009 The block SHALL have port out_pkt, output, PKT_W bits: packet to the memory interface.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_pkt is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the memory interface accepts out_pkt.
REQ-012 The block SHALL have ports grant_cnt0 and grant_cnt1, output, 16 bits each: grant statistics, present only under NOC_ARB_STATS_EN.

Function
REQ-013 The block SHALL transfer a packet on any interface only on a rising fclk edge where valid and ready are both 1.
REQ-014 The block SHALL drive inN_ready = 1 exactly when FIFO N holds fewer than DEPTH entries, derived from registered count only.
REQ-015 The block SHALL ignore a push when FIFO N is full, even if a pop of FIFO N occurs in the same cycle.
REQ-016 The block SHALL preserve arrival order per input; FIFO pointers wrap modulo DEPTH, and count is log2(DEPTH)+1 bits.
REQ-017 The block SHALL have an output register (out_pkt/out_valid) that loads when it is empty or is being consumed (out_valid & out_ready) and at least one FIFO is non-empty.
REQ-018 The block SHALL arbitrate round-robin: if only one FIFO is non-empty, grant it; if both are non-empty, grant the input not granted last; last_grant updates only on a load.
REQ-019 The block SHALL pop the granted FIFO in the same edge the output register loads.
REQ-020 The block SHALL have latency of exactly 1 cycle: a packet pushed at edge N into an empty FIFO with an empty/draining output register appears with out_valid=1 after edge N+1.
REQ-021 The block SHALL hold out_pkt and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 The block SHALL sustain throughput of one packet per cycle when out_ready=1 continuously.
REQ-023 The block SHALL clear out_valid at an edge where the register is consumed and both FIFOs are empty.
REQ-024 The block SHALL allow out_ready to be asserted without out_valid, with no effect.

Reset
REQ-025 The block SHALL, on assertion of rst, immediately (asynchronously) clear both FIFO counts and pointers, set out_valid=0, out_pkt=0, in0_ready=in1_ready=1 (after release), last_grant=1 (so input 0 wins the first tie), and clear grant counters.
REQ-026 The block SHALL discard all buffered and in-flight packets on reset mid-operation; no packet appears on out_pkt until pushed after reset release.
REQ-027 The block SHALL hold inN_ready=0 while rst=1.

Configuration
REQ-028 The block SHALL implement grant counters when macro NOC_ARB_STATS_EN is defined: grant_cnt0/grant_cnt1 increment on each output-register load granted to input 0/1 and saturate at 16'hFFFF.
REQ-029 The block SHALL omit the grant counter ports and logic when NOC_ARB_STATS_EN is undefined, with all other behaviour identical.

Verification
REQ-030 Single push: in0 pushes pkt 'hA5 at edge 1, out_ready=1 -> out_valid=1, out_pkt='hA5 after edge 2, out_valid=0 after edge 3.
REQ-031 Tie after reset: both inputs push at edge 1 (P0, P1) -> out order P0 then P1 on consecutive cycles; with stats, grant_cnt0=1 and grant_cnt1=1.
REQ-032 Backpressure/full: out_ready=0, DEPTH=2, in0 pushes 4 packets -> one packet in output register, 2 in FIFO, in0_ready=0, 4th packet held; out_pkt stable; on release order is preserved.
REQ-033 Fairness: both inputs continuously valid, out_ready=1 for 10 cycles -> grants alternate 0,1,0,1…, 5 packets each.
REQ-034 Reset mid-operation: assert rst with 3 packets buffered -> out_valid=0 immediately; after release no stale packet appears; new push emerges with 1-cycle latency.
REQ-035 Saturation (NOC_ARB_STATS_EN): force 70000 input-0 grants -> grant_cnt0=16'hFFFF and stays.

Source files
------------

// File: rtl/noc_arbiter.sv
// Two-input round-robin NoC arbiter: per-input FIFOs feed one registered output port.
// Define NOC_ARB_STATS_EN to add saturating per-input grant counters (grant_cnt0/grant_cnt1).
`timescale 1ns/1ps
module noc_arbiter #(
  parameter int unsigned PKT_W = 168,
  parameter int unsigned DEPTH = 2
) (
  input  logic             fclk,
  input  logic             rst,
  input  logic [PKT_W-1:0] in0_pkt,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [PKT_W-1:0] in1_pkt,
  input  logic             in1_valid,
  output logic             in1_ready,
  output logic [PKT_W-1:0] out_pkt,
  output logic             out_valid,
  input  logic             out_ready
`ifdef NOC_ARB_STATS_EN
  ,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] LP_FULL = CW'(DEPTH);

  logic [PKT_W-1:0] r_mem0 [DEPTH];
  logic [PKT_W-1:0] r_mem1 [DEPTH];
  logic [AW-1:0]    r_wptr0, r_rptr0, r_wptr1, r_rptr1;
  logic [CW-1:0]    r_cnt0, r_cnt1;
  logic [PKT_W-1:0] r_out_pkt;
  logic             r_out_valid;
  logic             r_last_grant;

  logic w_ready0, w_ready1;
  logic w_push0, w_push1;
  logic w_ne0, w_ne1;
  logic w_slot, w_load, w_gnt1;
  logic w_pop0, w_pop1;

  // Ready comes from the registered count only, so a full FIFO refuses a push even
  // when it is popped on the same edge.
  assign w_ready0 = ~rst & (r_cnt0 != LP_FULL);
  assign w_ready1 = ~rst & (r_cnt1 != LP_FULL);
  assign w_push0  = in0_valid & w_ready0;
  assign w_push1  = in1_valid & w_ready1;
  assign w_ne0    = (r_cnt0 != '0);
  assign w_ne1    = (r_cnt1 != '0);

  assign w_slot = ~r_out_valid | out_ready;
  assign w_load = w_slot & (w_ne0 | w_ne1);

  // On a tie the input not granted last wins; r_last_grant=1 means input 1 went last.
  always_comb begin
    w_gnt1 = w_ne1;
    if (w_ne0 && w_ne1) begin
      w_gnt1 = ~r_last_grant;
    end
  end

  assign w_pop0 = w_load & ~w_gnt1;
  assign w_pop1 = w_load & w_gnt1;

  always_ff @(posedge fclk) begin
    if (w_push0) begin
      r_mem0[r_wptr0] <= in0_pkt;
    end
    if (w_push1) begin
      r_mem1[r_wptr1] <= in1_pkt;
    end
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      r_wptr0 <= '0;
      r_rptr0 <= '0;
      r_cnt0  <= '0;
    end else begin
      if (w_push0) begin
        r_wptr0 <= r_wptr0 + 1'b1;
      end
      if (w_pop0) begin
        r_rptr0 <= r_rptr0 + 1'b1;
      end
      if (w_push0 && !w_pop0) begin
        r_cnt0 <= r_cnt0 + 1'b1;
      end else if (!w_push0 && w_pop0) begin
        r_cnt0 <= r_cnt0 - 1'b1;
      end
    end
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      r_wptr1 <= '0;
      r_rptr1 <= '0;
      r_cnt1  <= '0;
    end else begin
      if (w_push1) begin
        r_wptr1 <= r_wptr1 + 1'b1;
      end
      if (w_pop1) begin
        r_rptr1 <= r_rptr1 + 1'b1;
      end
      if (w_push1 && !w_pop1) begin
        r_cnt1 <= r_cnt1 + 1'b1;
      end else if (!w_push1 && w_pop1) begin
        r_cnt1 <= r_cnt1 - 1'b1;
      end
    end
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      r_out_pkt    <= '0;
      r_out_valid  <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_load) begin
      r_out_pkt    <= w_gnt1 ? r_mem1[r_rptr1] : r_mem0[r_rptr0];
      r_out_valid  <= 1'b1;
      r_last_grant <= w_gnt1;
    end else if (w_slot) begin
      r_out_valid  <= 1'b0;
    end
  end

`ifdef NOC_ARB_STATS_EN
  logic [15:0] r_gcnt0, r_gcnt1;

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      r_gcnt0 <= '0;
      r_gcnt1 <= '0;
    end else begin
      if (w_pop0 && (r_gcnt0 != 16'hFFFF)) begin
        r_gcnt0 <= r_gcnt0 + 16'd1;
      end
      if (w_pop1 && (r_gcnt1 != 16'hFFFF)) begin
        r_gcnt1 <= r_gcnt1 + 16'd1;
      end
    end
  end

  assign grant_cnt0 = r_gcnt0;
  assign grant_cnt1 = r_gcnt1;
`endif

  assign in0_ready = w_ready0;
  assign in1_ready = w_ready1;
  assign out_pkt   = r_out_pkt;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_noc_arbiter.sv
// Directed self-checking bench for noc_arbiter (DEPTH=2); stats checks only when
// NOC_ARB_STATS_EN is defined.
`timescale 1ns/1ps
module tb_noc_arbiter;

  localparam int unsigned PKT_W = 168;
  localparam int unsigned DEPTH = 2;

  logic             fclk = 1'b0;
  logic             rst = 1'b0;
  logic [PKT_W-1:0] in0_pkt = '0;
  logic             in0_valid = 1'b0;
  logic             in0_ready;
  logic [PKT_W-1:0] in1_pkt = '0;
  logic             in1_valid = 1'b0;
  logic             in1_ready;
  logic [PKT_W-1:0] out_pkt;
  logic             out_valid;
  logic             out_ready = 1'b0;
`ifdef NOC_ARB_STATS_EN
  logic [15:0]      grant_cnt0, grant_cnt1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  noc_arbiter #(.PKT_W(PKT_W), .DEPTH(DEPTH)) u_dut (
    .fclk      (fclk),
    .rst       (rst),
    .in0_pkt   (in0_pkt),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in1_pkt   (in1_pkt),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .out_pkt   (out_pkt),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef NOC_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  always #5 fclk = ~fclk;

  task automatic check_eq(input string tag, input logic [PKT_W-1:0] got,
                          input logic [PKT_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  task automatic do_reset();
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int n0, n1;

  initial begin
    // Reset state, checked while rst is still high
    #2 rst = 1'b1;
    #1;
    check_eq("rst_in0_ready", in0_ready, 0);
    check_eq("rst_in1_ready", in1_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_pkt", out_pkt, 0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("rel_in0_ready", in0_ready, 1);
    check_eq("rel_in1_ready", in1_ready, 1);
`ifdef NOC_ARB_STATS_EN
    check_eq("rst_gcnt0", grant_cnt0, 0);
    check_eq("rst_gcnt1", grant_cnt1, 0);
`endif

    // Single push, 1-cycle latency; out_ready high while idle has no effect
    out_ready = 1'b1;
    tick();
    check_eq("idle_valid", out_valid, 0);
    in0_pkt = 'hA5;
    in0_valid = 1'b1;
    tick();
    in0_valid = 1'b0;
    check_eq("single_e1_valid", out_valid, 0);
    tick();
    check_eq("single_e2_valid", out_valid, 1);
    check_eq("single_e2_pkt", out_pkt, 'hA5);
    tick();
    check_eq("single_e3_valid", out_valid, 0);

    // Tie after reset: input 0 first
    do_reset();
    out_ready = 1'b1;
    in0_pkt = 'h100;
    in1_pkt = 'h201;
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    tick();
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    tick();
    check_eq("tie_first_valid", out_valid, 1);
    check_eq("tie_first_pkt", out_pkt, 'h100);
    tick();
    check_eq("tie_second_valid", out_valid, 1);
    check_eq("tie_second_pkt", out_pkt, 'h201);
    tick();
    check_eq("tie_drain_valid", out_valid, 0);
`ifdef NOC_ARB_STATS_EN
    check_eq("tie_gcnt0", grant_cnt0, 1);
    check_eq("tie_gcnt1", grant_cnt1, 1);
`endif

    // Backpressure and full FIFO
    do_reset();
    in0_valid = 1'b1;
    in0_pkt = 'hB0;
    tick();
    in0_pkt = 'hB1;
    tick();
    check_eq("bp_e2_pkt", out_pkt, 'hB0);
    in0_pkt = 'hB2;
    tick();
    in0_pkt = 'hB3;
    check_eq("bp_full_ready", in0_ready, 0);
    tick();
    check_eq("bp_hold_ready", in0_ready, 0);
    check_eq("bp_hold_valid", out_valid, 1);
    check_eq("bp_hold_pkt", out_pkt, 'hB0);
    tick();
    check_eq("bp_hold2_pkt", out_pkt, 'hB0);
    out_ready = 1'b1;
    tick();
    check_eq("bp_rel1_pkt", out_pkt, 'hB1);
    tick();
    in0_valid = 1'b0;
    check_eq("bp_rel2_pkt", out_pkt, 'hB2);
    tick();
    check_eq("bp_rel3_pkt", out_pkt, 'hB3);
    check_eq("bp_rel3_valid", out_valid, 1);
    tick();
    check_eq("bp_empty_valid", out_valid, 0);

    // Fairness: both inputs always valid
    do_reset();
    out_ready = 1'b1;
    in0_pkt = 'hC0;
    in1_pkt = 'hC1;
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    tick();
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq($sformatf("fair_pkt_%0d", i), out_pkt, (i % 2 == 0) ? 'hC0 : 'hC1);
      if (out_valid && out_pkt == 'hC0) n0++;
      if (out_valid && out_pkt == 'hC1) n1++;
    end
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    check_eq("fair_n0", n0, 5);
    check_eq("fair_n1", n1, 5);

    // Reset mid-operation with three packets buffered
    do_reset();
    in0_valid = 1'b1;
    in0_pkt = 'hD0;
    tick();
    in0_pkt = 'hD1;
    tick();
    in0_pkt = 'hD2;
    tick();
    in0_valid = 1'b0;
    check_eq("mid_pre_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_async_valid", out_valid, 0);
    check_eq("mid_async_ready", in0_ready, 0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    check_eq("mid_stale_valid", out_valid, 0);
    in1_pkt = 'hE0;
    in1_valid = 1'b1;
    tick();
    in1_valid = 1'b0;
    check_eq("mid_new_e1_valid", out_valid, 0);
    tick();
    check_eq("mid_new_e2_valid", out_valid, 1);
    check_eq("mid_new_e2_pkt", out_pkt, 'hE0);

`ifdef NOC_ARB_STATS_EN
    // Saturation of the input-0 grant counter
    do_reset();
    out_ready = 1'b1;
    in0_pkt = 'hF0;
    in0_valid = 1'b1;
    repeat (70010) tick();
    check_eq("sat_gcnt0", grant_cnt0, 16'hFFFF);
    repeat (5) tick();
    check_eq("sat_gcnt0_hold", grant_cnt0, 16'hFFFF);
    check_eq("sat_gcnt1", grant_cnt1, 0);
    in0_valid = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
